// File: rtl/pio_rd_arb_if.sv
// PIO read channel bundle: address handshake plus read-data handshake.
// N channels share one bundle, with channel i at [i*AW +: AW] / [i*DW +: DW] / bit i.
// The master side issues addresses and accepts data; the slave side accepts
// addresses and returns data.
interface pio_rd_arb_if #(
  parameter int N  = 1,
  parameter int AW = 32,
  parameter int DW = 32
) ();

  logic [N*AW-1:0] addr;
  logic [N-1:0]    avalid;
  logic [N-1:0]    aready;
  logic [N*DW-1:0] data;
  logic [N-1:0]    dvalid;
  logic [N-1:0]    dready;
  logic [N-1:0]    resp;

  modport master (
    output addr, avalid, dready,
    input  aready, data, dvalid, resp
  );

  modport slave (
    input  addr, avalid, dready,
    output aready, data, dvalid, resp
  );

endinterface

// File: rtl/pio_rd_arb.sv
// N-initiator PIO read arbiter.
// Initiator address requests are merged round-robin onto a single registered
// target address stage. The channel of every issued read is queued in order,
// and the queue head steers the combinational response path back to the
// right initiator. If the head waits too long, the initiator gets an error
// beat, and the target's late beat is drained later through a drop counter.
module pio_rd_arb #(
  parameter int          N_INIT    = 4,
  parameter int          AW        = 32,
  parameter int          DW        = 32,
  parameter int          MAX_OUTST = 4,
  parameter int          TIMEOUT   = 1024,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic             clk,
  input  logic             reset,
  pio_rd_arb_if.slave      m,
  pio_rd_arb_if.master     s,
  output logic             err_spurious,
  output logic [7:0]       timeout_cnt
);

  localparam int IDW = (N_INIT > 1) ? $clog2(N_INIT) : 1;
  localparam int AD  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int TW  = $clog2(TIMEOUT + 1);

  localparam logic [DW-1:0] ERR_WORD  = DW'(ERR_DATA);
  localparam logic [AD:0]   OUTST_MAX = (AD + 1)'(MAX_OUTST);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic {
    ST_IDLE,
    ST_ERR
  } state_t;

  state_t state;
  state_t state_nxt;

  // Target address stage.
  logic          stg_valid;
  logic [AW-1:0] stg_addr;
  logic          stage_free;

  // Round-robin arbitration.
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] scan_idx;
  logic [IDW-1:0] gnt_idx;
  logic           req_found;
  logic           grant;
  logic [N_INIT-1:0] aready_c;

  // In-order ID queue of issuing channels.
  logic [IDW-1:0] id_mem [MAX_OUTST];
  logic [AD-1:0]  wr_ptr;
  logic [AD-1:0]  rd_ptr;
  logic [AD:0]    fifo_cnt;
  logic           fifo_empty;
  logic [IDW-1:0] head;

  // Reads abandoned by a timeout whose target beat is still to come.
  logic [AD:0]    drop_cnt;
  logic [AD:0]    outst;

  // Head wait counter.
  logic [TW-1:0]  tmo_ctr;

  // Response-side decisions.
  logic              route_pop;
  logic              err_pop;
  logic              pop;
  logic              drop_take;
  logic              spur_take;
  logic              tmo_run;
  logic              tmo_hit;
  logic [N_INIT-1:0]    dvalid_c;
  logic [N_INIT*DW-1:0] data_c;
  logic [N_INIT-1:0]    resp_c;
  logic                 s_dready_c;

  assign fifo_empty = (fifo_cnt == '0);
  assign head       = id_mem[rd_ptr];
  assign outst      = fifo_cnt + drop_cnt;
  assign stage_free = !stg_valid || s.aready[0];
  assign pop        = route_pop || err_pop;

  // Drive the target address from the stage register.
  assign s.avalid = stg_valid;
  assign s.addr   = stg_addr;

  // Hold every combinational output low while reset is asserted.
  assign m.aready = reset ? '0 : aready_c;
  assign m.dvalid = reset ? '0 : dvalid_c;
  assign m.data   = reset ? '0 : data_c;
  assign m.resp   = reset ? '0 : resp_c;
  assign s.dready = reset ? 1'b0 : s_dready_c;

  // Find the first requesting channel at or after the round-robin pointer.
  always_comb begin
    req_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < N_INIT; k++) begin
      scan_idx = IDW'((int'(rr_ptr) + k) % N_INIT);
      if (!req_found && m.avalid[scan_idx]) begin
        req_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  // Grant when the stage can take a new address and a tracking slot is free or
  // is being freed this very cycle (an ERR pop only moves a slot to drop_cnt,
  // so it does not free one).
  always_comb begin
    aready_c = '0;
    grant    = req_found && stage_free && !reset &&
               ((outst < OUTST_MAX) || route_pop || drop_take);
    if (grant) begin
      aready_c[gnt_idx] = 1'b1;
    end
  end

  // Response steering and next-state selection for the IDLE/ERR machine.
  always_comb begin
    state_nxt  = state;
    dvalid_c   = '0;
    data_c     = '0;
    resp_c     = '0;
    s_dready_c = 1'b0;
    route_pop  = 1'b0;
    err_pop    = 1'b0;
    drop_take  = 1'b0;
    spur_take  = 1'b0;
    tmo_run    = 1'b0;
    tmo_hit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (drop_cnt != '0) begin
          s_dready_c = 1'b1;
          drop_take  = s.dvalid[0];
        end else if (fifo_empty) begin
          s_dready_c = 1'b1;
          spur_take  = s.dvalid[0];
        end else begin
          dvalid_c[head]                 = s.dvalid[0];
          data_c[int'(head)*DW +: DW]    = s.data;
          resp_c[head]                   = s.resp[0];
          s_dready_c                     = m.dready[head];
          route_pop                      = s.dvalid[0] && m.dready[head];
          tmo_run                        = !s.dvalid[0];
          if (tmo_run && (tmo_ctr == TMO_LAST)) begin
            tmo_hit   = 1'b1;
            state_nxt = ST_ERR;
          end
        end
      end
      ST_ERR: begin
        dvalid_c[head]              = 1'b1;
        data_c[int'(head)*DW +: DW] = ERR_WORD;
        resp_c[head]                = 1'b1;
        s_dready_c                  = 1'b0;
        err_pop                     = m.dready[head];
        if (err_pop) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Load the address stage on a grant, empty it once the target accepts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stg_valid <= 1'b0;
      stg_addr  <= '0;
    end else if (grant) begin
      stg_valid <= 1'b1;
      stg_addr  <= m.addr[int'(gnt_idx)*AW +: AW];
    end else if (s.aready[0]) begin
      stg_valid <= 1'b0;
    end
  end

  // Advance the round-robin pointer past the granted channel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= IDW'((int'(gnt_idx) + 1) % N_INIT);
    end
  end

  // Store the issuing channel of each granted read.
  always_ff @(posedge clk) begin
    if (grant) begin
      id_mem[wr_ptr] <= gnt_idx;
    end
  end

  // ID queue pointers and occupancy; push and pop together leave it unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (grant) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({grant, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Count target beats still owed for timed-out reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (err_pop) begin
      drop_cnt <= drop_cnt + 1'b1;
    end else if (drop_take) begin
      drop_cnt <= drop_cnt - 1'b1;
    end
  end

  // Measure how long the head read has waited for its target beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_ctr <= '0;
    end else if (pop || tmo_hit) begin
      tmo_ctr <= '0;
    end else if (tmo_run) begin
      tmo_ctr <= tmo_ctr + 1'b1;
    end
  end

  // Sticky flag for target beats that match no outstanding read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_spurious <= 1'b0;
    end else if (spur_take) begin
      err_spurious <= 1'b1;
    end
  end

  // Saturating count of error beats delivered to initiators.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_cnt <= '0;
    end else if (err_pop && (timeout_cnt != 8'hFF)) begin
      timeout_cnt <= timeout_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pio_rd_arb.sv
// Directed bench for pio_rd_arb: 4 initiators, 4 outstanding, timeout of 16.
module tb_pio_rd_arb;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic       clk;
  logic       reset;
  logic       err_spurious;
  logic [7:0] timeout_cnt;

  int checks = 0;
  int errors = 0;

  pio_rd_arb_if #(.N(N), .AW(AW), .DW(DW)) m_bus ();
  pio_rd_arb_if #(.N(1), .AW(AW), .DW(DW)) s_bus ();

  pio_rd_arb #(
    .N_INIT   (N),
    .AW       (AW),
    .DW       (DW),
    .MAX_OUTST(4),
    .TIMEOUT  (16),
    .ERR_DATA (32'hDEAD_BEEF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .m           (m_bus.slave),
    .s           (s_bus.master),
    .err_spurious(err_spurious),
    .timeout_cnt (timeout_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_aready"}, 64'(m_bus.aready), 64'h0);
    check_output({tag, "_dvalid"}, 64'(m_bus.dvalid), 64'h0);
    check_output({tag, "_mdata"}, 64'(m_bus.data[63:0]), 64'h0);
    check_output({tag, "_mdata_hi"}, 64'(m_bus.data[127:64]), 64'h0);
    check_output({tag, "_resp"}, 64'(m_bus.resp), 64'h0);
    check_output({tag, "_savalid"}, 64'(s_bus.avalid), 64'h0);
    check_output({tag, "_saddr"}, 64'(s_bus.addr), 64'h0);
    check_output({tag, "_sdready"}, 64'(s_bus.dready), 64'h0);
    check_output({tag, "_spur"}, 64'(err_spurious), 64'h0);
    check_output({tag, "_tmo"}, 64'(timeout_cnt), 64'h0);
  endtask

  initial begin
    reset         = 1'b1;
    m_bus.addr    = '0;
    m_bus.avalid  = '0;
    m_bus.dready  = '0;
    s_bus.aready  = 1'b0;
    s_bus.data    = '0;
    s_bus.dvalid  = 1'b0;
    s_bus.resp    = 1'b0;

    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset        = 1'b0;
    s_bus.aready = 1'b1;
    m_bus.dready = 4'hF;

    // Fairness: all channels request, target answers every cycle after the first.
    @(negedge clk);
    m_bus.avalid = 4'hF;
    m_bus.addr   = {32'h1C, 32'h18, 32'h14, 32'h10};
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        s_bus.dvalid = 1'b1;
        s_bus.data   = 32'hD000_0000 + 32'(i);
      end
      #1;
      check_output("fair_gnt", 64'(m_bus.aready), 64'(1) << (i % 4));
      if (i > 0) check_output("fair_route", 64'(m_bus.dvalid), 64'(1) << ((i - 1) % 4));
      else       check_output("fair_first_dvalid", 64'(m_bus.dvalid), 64'h0);
      @(negedge clk);
    end
    m_bus.avalid = '0;
    #1;
    check_output("fair_last_route", 64'(m_bus.dvalid), 64'h1);
    check_output("fair_last_data", 64'(m_bus.data[31:0]), 64'hD000_0004);
    @(negedge clk);
    s_bus.dvalid = 1'b0;
    #1;
    check_output("fair_idle", 64'(m_bus.dvalid), 64'h0);

    // Single read on channel 1.
    @(negedge clk);
    m_bus.addr[63:32] = 32'h100;
    m_bus.avalid      = 4'b0010;
    #1;
    check_output("single_gnt", 64'(m_bus.aready), 64'h2);
    @(negedge clk);
    m_bus.avalid = '0;
    #1;
    check_output("single_savalid", 64'(s_bus.avalid), 64'h1);
    check_output("single_saddr", 64'(s_bus.addr), 64'h100);
    @(negedge clk);
    #1;
    check_output("single_stage_drain", 64'(s_bus.avalid), 64'h0);
    @(negedge clk);
    @(negedge clk);
    s_bus.dvalid = 1'b1;
    s_bus.data   = 32'hA5A5_0001;
    s_bus.resp   = 1'b0;
    #1;
    check_output("single_dvalid", 64'(m_bus.dvalid), 64'h2);
    check_output("single_data", 64'(m_bus.data[63:32]), 64'hA5A5_0001);
    check_output("single_resp", 64'(m_bus.resp), 64'h0);
    check_output("single_sdready", 64'(s_bus.dready), 64'h1);
    @(negedge clk);
    s_bus.dvalid = 1'b0;
    #1;
    check_output("single_done", 64'(m_bus.dvalid), 64'h0);

    // Outstanding limit: four reads fill the tracker, the fifth must wait.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      m_bus.avalid = 4'(1 << ((k + 2) % 4));
      m_bus.addr[((k + 2) % 4)*32 +: 32] = 32'h2000 + 32'(k * 4);
      #1;
      check_output("limit_gnt", 64'(m_bus.aready), 64'(1) << ((k + 2) % 4));
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      m_bus.avalid = 4'b0100;
      m_bus.addr[95:64] = 32'h2010;
      #1;
      check_output("limit_stall", 64'(m_bus.aready), 64'h0);
    end
    @(negedge clk);
    s_bus.dvalid = 1'b1;
    s_bus.data   = 32'hB0;
    #1;
    check_output("limit_pop_route", 64'(m_bus.dvalid), 64'h4);
    check_output("limit_pop_data", 64'(m_bus.data[95:64]), 64'hB0);
    check_output("limit_gnt_on_pop", 64'(m_bus.aready), 64'h4);
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      m_bus.avalid = '0;
      s_bus.data   = 32'hB0 + 32'(k);
      #1;
      check_output("limit_order", 64'(m_bus.dvalid), 64'(1) << ((k + 2) % 4));
      check_output("limit_data", 64'(m_bus.data[((k + 2) % 4)*32 +: 32]), 64'hB0 + 64'(k));
    end
    @(negedge clk);
    s_bus.dvalid = 1'b0;
    #1;
    check_output("limit_done", 64'(m_bus.dvalid), 64'h0);

    // Backpressure: channel 0 holds off its data for five cycles.
    @(negedge clk);
    m_bus.avalid      = 4'b0001;
    m_bus.addr[31:0]  = 32'h200;
    #1;
    check_output("bp_gnt", 64'(m_bus.aready), 64'h1);
    @(negedge clk);
    m_bus.avalid = '0;
    m_bus.dready = '0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (j == 0) begin
        s_bus.dvalid = 1'b1;
        s_bus.data   = 32'hC0C0_0001;
      end
      #1;
      check_output("bp_sdready", 64'(s_bus.dready), 64'h0);
      check_output("bp_hold_valid", 64'(m_bus.dvalid), 64'h1);
      check_output("bp_hold_data", 64'(m_bus.data[31:0]), 64'hC0C0_0001);
    end
    @(negedge clk);
    m_bus.dready = 4'hF;
    #1;
    check_output("bp_release", 64'(s_bus.dready), 64'h1);
    @(negedge clk);
    s_bus.dvalid = 1'b0;
    #1;
    check_output("bp_done", 64'(m_bus.dvalid), 64'h0);

    // Timeout: channel 3 reads and the target stays silent.
    @(negedge clk);
    m_bus.avalid      = 4'b1000;
    m_bus.addr[127:96] = 32'h300;
    m_bus.dready      = '0;
    #1;
    check_output("tmo_gnt", 64'(m_bus.aready), 64'h8);
    @(negedge clk);
    m_bus.avalid = '0;
    for (int j = 2; j <= 16; j++) begin
      @(negedge clk);
    end
    #1;
    check_output("tmo_early", 64'(m_bus.dvalid), 64'h0);
    @(negedge clk);
    #1;
    check_output("tmo_err_valid", 64'(m_bus.dvalid), 64'h8);
    check_output("tmo_err_data", 64'(m_bus.data[127:96]), 64'hDEAD_BEEF);
    check_output("tmo_err_resp", 64'(m_bus.resp), 64'h8);
    check_output("tmo_err_sdready", 64'(s_bus.dready), 64'h0);
    @(negedge clk);
    s_bus.dvalid = 1'b1;
    s_bus.data   = 32'h1234_5678;
    #1;
    check_output("tmo_late_blocked", 64'(s_bus.dready), 64'h0);
    check_output("tmo_err_data_hold", 64'(m_bus.data[127:96]), 64'hDEAD_BEEF);
    check_output("tmo_cnt_before", 64'(timeout_cnt), 64'h0);
    @(negedge clk);
    m_bus.dready = 4'hF;
    #1;
    check_output("tmo_err_accept", 64'(m_bus.dvalid), 64'h8);
    @(negedge clk);
    #1;
    check_output("tmo_cnt", 64'(timeout_cnt), 64'h1);
    check_output("tmo_drain_dvalid", 64'(m_bus.dvalid), 64'h0);
    check_output("tmo_drain_sdready", 64'(s_bus.dready), 64'h1);
    @(negedge clk);
    s_bus.dvalid = 1'b0;
    #1;
    check_output("tmo_no_spur", 64'(err_spurious), 64'h0);
    @(negedge clk);
    m_bus.avalid      = 4'b0010;
    m_bus.addr[63:32] = 32'h400;
    #1;
    check_output("tmo_next_gnt", 64'(m_bus.aready), 64'h2);
    @(negedge clk);
    m_bus.avalid = '0;
    #1;
    check_output("tmo_next_saddr", 64'(s_bus.addr), 64'h400);
    @(negedge clk);
    s_bus.dvalid = 1'b1;
    s_bus.data   = 32'h5555_0002;
    #1;
    check_output("tmo_next_route", 64'(m_bus.dvalid), 64'h2);
    check_output("tmo_next_data", 64'(m_bus.data[63:32]), 64'h5555_0002);
    check_output("tmo_next_resp", 64'(m_bus.resp), 64'h0);
    @(negedge clk);
    s_bus.dvalid = 1'b0;

    // Spurious beat with nothing outstanding.
    @(negedge clk);
    s_bus.dvalid = 1'b1;
    s_bus.data   = 32'h77;
    #1;
    check_output("spur_sdready", 64'(s_bus.dready), 64'h1);
    check_output("spur_no_route", 64'(m_bus.dvalid), 64'h0);
    @(negedge clk);
    s_bus.dvalid = 1'b0;
    #1;
    check_output("spur_flag", 64'(err_spurious), 64'h1);

    // Asynchronous reset in the middle of a read.
    @(negedge clk);
    s_bus.aready      = 1'b0;
    m_bus.avalid      = 4'b0100;
    m_bus.addr[95:64] = 32'h500;
    #1;
    check_output("rst_gnt", 64'(m_bus.aready), 64'h4);
    @(negedge clk);
    m_bus.avalid = '0;
    #1;
    check_output("rst_pre_savalid", 64'(s_bus.avalid), 64'h1);
    check_output("rst_pre_saddr", 64'(s_bus.addr), 64'h500);
    #2;
    reset        = 1'b1;
    s_bus.dvalid = 1'b1;
    m_bus.avalid = 4'hF;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    reset        = 1'b0;
    s_bus.dvalid = 1'b0;
    m_bus.avalid = '0;
    s_bus.aready = 1'b1;
    #1;
    check_output("post_rst_savalid", 64'(s_bus.avalid), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
